scon_pack: RTL and testbench

Shift-concatenation stage between the compression module and the output/encryption path. Accepts variable-length compressed fragments (0–64 valid bits per beat, LSB-aligned) and packs them MSB-first into 64-bit words. Pulses `scon_done` with each completed word, which the top-level control block turns into `out_valid`. Honours `stall` and drains a partial word on `dump_comp`.

---
 rtl/scon_pack_if.sv | 27 ++
 rtl/scon_pack.sv | 143 ++++++++++++++
 tb/tb_scon_pack.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/scon_pack_if.sv
// Fragment-in / packed-word-out bundle for scon_pack.
// The master side is the compression/control path; the slave side is the packer.
interface scon_pack_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             comp_valid;
  logic [63:0]      comp_data;
  logic [6:0]       valid_bits;
  logic             dump_comp;
  logic [63:0]      out_data;
  logic             scon_done;
  logic [6:0]       last_bits;
  logic [5:0]       fill_level;
  logic [CNT_W-1:0] word_count;
  logic             bits_error;

  modport master (
    output stall, comp_valid, comp_data, valid_bits, dump_comp,
    input  out_data, scon_done, last_bits, fill_level, word_count, bits_error
  );

  modport slave (
    input  stall, comp_valid, comp_data, valid_bits, dump_comp,
    output out_data, scon_done, last_bits, fill_level, word_count, bits_error
  );
endinterface

// File: rtl/scon_pack.sv
// Packs 0..64-bit LSB-aligned fragments MSB-first into 64-bit words, with flush on dump_comp.
// Define SCON_PAD_ONES_EN to pad flushed partial words with 1s instead of 0s.
module scon_pack #(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  scon_pack_if.slave bus
);

  typedef enum logic {ACCUM = 1'b0, FLUSH = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [63:0]      r_acc;
  logic [5:0]       r_fill;
  logic [63:0]      r_out_data;
  logic             r_done;
  logic [6:0]       r_last_bits;
  logic [CNT_W-1:0] r_word_count;
  logic             r_bits_error;

  logic             w_live;
  logic             w_beat;
  logic             w_accept;
  logic             w_bad;
  logic             w_dump;
  logic [6:0]       w_vb;
  logic [63:0]      w_mask;
  logic [63:0]      w_frag;
  logic [127:0]     w_cat;
  logic [6:0]       w_total;
  logic [63:0]      w_acc_nxt;
  logic [5:0]       w_fill_nxt;
  logic [63:0]      w_out_nxt;
  logic [6:0]       w_last_nxt;
  logic             w_emit;
  logic             w_err_nxt;

  // Unused LSBs below the n valid bits of a flushed word get the configured pad value.
  function automatic logic [63:0] pad_word(input logic [63:0] d, input logic [5:0] n);
`ifdef SCON_PAD_ONES_EN
    pad_word = d | ({64{1'b1}} >> n);
`else
    pad_word = d & ~({64{1'b1}} >> n);
`endif
  endfunction

  assign w_live   = ~bus.stall & ~r_bits_error;
  assign w_beat   = bus.comp_valid & w_live & (r_state == ACCUM);
  assign w_accept = w_beat & (bus.valid_bits <= 7'd64);
  assign w_bad    = w_beat & (bus.valid_bits > 7'd64);
  assign w_dump   = bus.dump_comp & w_live & (r_state == ACCUM);
  assign w_vb     = w_accept ? bus.valid_bits : 7'd0;
  assign w_mask   = (w_vb == 7'd64) ? {64{1'b1}} : ((64'd1 << w_vb) - 64'd1);
  assign w_frag   = bus.comp_data & w_mask;

  // 128-bit view: held bits at the top, new fragment left-aligned directly beneath them.
  assign w_cat    = {r_acc, 64'd0} | (({w_frag, 64'd0} << (7'd64 - w_vb)) >> r_fill);
  assign w_total  = {1'b0, r_fill} + w_vb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ACCUM;
      r_acc        <= '0;
      r_fill       <= '0;
      r_out_data   <= '0;
      r_done       <= 1'b0;
      r_last_bits  <= '0;
      r_word_count <= '0;
      r_bits_error <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_fill       <= w_fill_nxt;
      r_out_data   <= w_out_nxt;
      r_done       <= w_emit;
      r_last_bits  <= w_last_nxt;
      r_bits_error <= w_err_nxt;
      if (w_emit) r_word_count <= r_word_count + 1'b1;
    end
  end

  // FLUSH is entered only when a dump overflows and leaves a remainder behind.
  always_comb begin
    w_state_nxt = r_state;
    if (!bus.stall) begin
      case (r_state)
        ACCUM:   if (w_dump && (w_total > 7'd64)) w_state_nxt = FLUSH;
        FLUSH:   w_state_nxt = ACCUM;
        default: w_state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    w_acc_nxt  = r_acc;
    w_fill_nxt = r_fill;
    w_out_nxt  = r_out_data;
    w_last_nxt = r_last_bits;
    w_emit     = 1'b0;
    w_err_nxt  = r_bits_error | w_bad;
    if (!bus.stall) begin
      case (r_state)
        ACCUM: begin
          if (w_total >= 7'd64) begin
            w_emit     = 1'b1;
            w_out_nxt  = w_cat[127:64];
            w_last_nxt = 7'd64;
            w_acc_nxt  = w_cat[63:0];
            w_fill_nxt = w_total[5:0];
          end else if (w_dump && (w_total != 7'd0)) begin
            w_emit     = 1'b1;
            w_out_nxt  = pad_word(w_cat[127:64], w_total[5:0]);
            w_last_nxt = w_total;
            w_acc_nxt  = '0;
            w_fill_nxt = '0;
          end else begin
            w_acc_nxt  = w_cat[127:64];
            w_fill_nxt = w_total[5:0];
          end
        end
        FLUSH: begin
          w_emit     = 1'b1;
          w_out_nxt  = pad_word(r_acc, r_fill);
          w_last_nxt = {1'b0, r_fill};
          w_acc_nxt  = '0;
          w_fill_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  // The done pulse is also masked combinationally so stall silences it within the cycle.
  assign bus.out_data   = r_out_data;
  assign bus.scon_done  = r_done & ~bus.stall;
  assign bus.last_bits  = r_last_bits;
  assign bus.fill_level = r_fill;
  assign bus.word_count = r_word_count;
  assign bus.bits_error = r_bits_error;

endmodule

// File: tb/tb_scon_pack.sv
// Directed bench for scon_pack: packing, dump, dump-overflow, stall, back-to-back, no-ops, error and reset.
module tb_scon_pack;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  scon_pack_if #(.CNT_W(16)) bus ();

  scon_pack #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef SCON_PAD_ONES_EN
  localparam logic [63:0] EXP_DUMP  = 64'hABCD_FFFF_FFFF_FFFF;
  localparam logic [63:0] EXP_FLUSH = 64'hCCDD_EEFF_FFFF_FFFF;
`else
  localparam logic [63:0] EXP_DUMP  = 64'hABCD_0000_0000_0000;
  localparam logic [63:0] EXP_FLUSH = 64'hCCDD_EE00_0000_0000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall      = 1'b0;
    bus.comp_valid = 1'b0;
    bus.comp_data  = '0;
    bus.valid_bits = '0;
    bus.dump_comp  = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic [6:0] vb, input logic dump);
    bus.comp_valid = 1'b1;
    bus.comp_data  = d;
    bus.valid_bits = vb;
    bus.dump_comp  = dump;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_data !== 64'd0) begin errors++; $display("[TB] FAIL reset_out: got %h want 0", bus.out_data); end
    checks++; if (bus.scon_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", bus.scon_done); end
    checks++; if (bus.last_bits !== 7'd0) begin errors++; $display("[TB] FAIL reset_last: got %0d want 0", bus.last_bits); end
    checks++; if (bus.fill_level !== 6'd0) begin errors++; $display("[TB] FAIL reset_fill: got %0d want 0", bus.fill_level); end
    checks++; if (bus.word_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", bus.word_count); end
    checks++; if (bus.bits_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", bus.bits_error); end
  endtask

  task automatic test_pack();
    beat({64{1'b1}}, 7'd40, 1'b0);
    step();
    checks++; if (bus.fill_level !== 6'd40) begin errors++; $display("[TB] FAIL pack_fill40: got %0d want 40", bus.fill_level); end
    checks++; if (bus.scon_done !== 1'b0) begin errors++; $display("[TB] FAIL pack_nodone: got %b want 0", bus.scon_done); end
    beat(64'd0, 7'd40, 1'b0);
    step();
    idle();
    checks++; if (bus.out_data !== 64'hFFFF_FFFF_FF00_0000) begin errors++; $display("[TB] FAIL pack_out: got %h want ffffffffff000000", bus.out_data); end
    checks++; if (bus.last_bits !== 7'd64) begin errors++; $display("[TB] FAIL pack_last: got %0d want 64", bus.last_bits); end
    checks++; if (bus.scon_done !== 1'b1) begin errors++; $display("[TB] FAIL pack_done: got %b want 1", bus.scon_done); end
    checks++; if (bus.fill_level !== 6'd16) begin errors++; $display("[TB] FAIL pack_fill16: got %0d want 16", bus.fill_level); end
    checks++; if (bus.word_count !== 16'd1) begin errors++; $display("[TB] FAIL pack_count: got %0d want 1", bus.word_count); end
    step();
    checks++; if (bus.scon_done !== 1'b0) begin errors++; $display("[TB] FAIL pack_pulse: got %b want 0", bus.scon_done); end
  endtask

  task automatic test_dump();
    do_reset();
    beat(64'h1234_5678_9ABC_ABCD, 7'd16, 1'b0);
    step();
    checks++; if (bus.fill_level !== 6'd16) begin errors++; $display("[TB] FAIL dump_fill16: got %0d want 16", bus.fill_level); end
    idle();
    bus.dump_comp = 1'b1;
    step();
    idle();
    checks++; if (bus.scon_done !== 1'b1) begin errors++; $display("[TB] FAIL dump_done: got %b want 1", bus.scon_done); end
    checks++; if (bus.out_data !== EXP_DUMP) begin errors++; $display("[TB] FAIL dump_out: got %h want %h", bus.out_data, EXP_DUMP); end
    checks++; if (bus.last_bits !== 7'd16) begin errors++; $display("[TB] FAIL dump_last: got %0d want 16", bus.last_bits); end
    checks++; if (bus.fill_level !== 6'd0) begin errors++; $display("[TB] FAIL dump_fill0: got %0d want 0", bus.fill_level); end
    checks++; if (bus.word_count !== 16'd1) begin errors++; $display("[TB] FAIL dump_count: got %0d want 1", bus.word_count); end
    step();
    checks++; if (bus.scon_done !== 1'b0) begin errors++; $display("[TB] FAIL dump_pulse: got %b want 0", bus.scon_done); end
  endtask

  task automatic test_dump_overflow();
    beat(64'hFFFF_1111_2222_3333, 7'd48, 1'b0);
    step();
    checks++; if (bus.fill_level !== 6'd48) begin errors++; $display("[TB] FAIL ovf_fill48: got %0d want 48", bus.fill_level); end
    beat(64'h0000_00AA_BBCC_DDEE, 7'd40, 1'b1);
    step();
    idle();
    checks++; if (bus.scon_done !== 1'b1) begin errors++; $display("[TB] FAIL ovf_done1: got %b want 1", bus.scon_done); end
    checks++; if (bus.out_data !== 64'h1111_2222_3333_AABB) begin errors++; $display("[TB] FAIL ovf_out1: got %h want 111122223333aabb", bus.out_data); end
    checks++; if (bus.last_bits !== 7'd64) begin errors++; $display("[TB] FAIL ovf_last1: got %0d want 64", bus.last_bits); end
    checks++; if (bus.fill_level !== 6'd24) begin errors++; $display("[TB] FAIL ovf_fill24: got %0d want 24", bus.fill_level); end
    checks++; if (bus.word_count !== 16'd2) begin errors++; $display("[TB] FAIL ovf_count1: got %0d want 2", bus.word_count); end
    step();
    checks++; if (bus.scon_done !== 1'b1) begin errors++; $display("[TB] FAIL ovf_done2: got %b want 1", bus.scon_done); end
    checks++; if (bus.out_data !== EXP_FLUSH) begin errors++; $display("[TB] FAIL ovf_out2: got %h want %h", bus.out_data, EXP_FLUSH); end
    checks++; if (bus.last_bits !== 7'd24) begin errors++; $display("[TB] FAIL ovf_last2: got %0d want 24", bus.last_bits); end
    checks++; if (bus.fill_level !== 6'd0) begin errors++; $display("[TB] FAIL ovf_fill0: got %0d want 0", bus.fill_level); end
    checks++; if (bus.word_count !== 16'd3) begin errors++; $display("[TB] FAIL ovf_count2: got %0d want 3", bus.word_count); end
    step();
    checks++; if (bus.scon_done !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pulse: got %b want 0", bus.scon_done); end
  endtask

  task automatic test_stall();
    beat(64'h0123_4567_89AB_CDEF, 7'd64, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.scon_done !== 1'b0) begin errors++; $display("[TB] FAIL stall_done[%0d]: got %b want 0", i, bus.scon_done); end
      checks++; if (bus.fill_level !== 6'd0) begin errors++; $display("[TB] FAIL stall_fill[%0d]: got %0d want 0", i, bus.fill_level); end
      checks++; if (bus.word_count !== 16'd3) begin errors++; $display("[TB] FAIL stall_count[%0d]: got %0d want 3", i, bus.word_count); end
    end
    bus.stall = 1'b0;
    step();
    idle();
    checks++; if (bus.scon_done !== 1'b1) begin errors++; $display("[TB] FAIL stall_rel_done: got %b want 1", bus.scon_done); end
    checks++; if (bus.out_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("[TB] FAIL stall_rel_out: got %h want 0123456789abcdef", bus.out_data); end
    checks++; if (bus.word_count !== 16'd4) begin errors++; $display("[TB] FAIL stall_rel_count: got %0d want 4", bus.word_count); end
    step();
  endtask

  task automatic test_back_to_back();
    beat(64'hDEAD_BEEF_0000_0001, 7'd64, 1'b0);
    step();
    beat(64'hCAFE_F00D_1234_5678, 7'd64, 1'b0);
    checks++; if (bus.scon_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done1: got %b want 1", bus.scon_done); end
    checks++; if (bus.out_data !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("[TB] FAIL b2b_out1: got %h want deadbeef00000001", bus.out_data); end
    step();
    idle();
    checks++; if (bus.scon_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done2: got %b want 1", bus.scon_done); end
    checks++; if (bus.out_data !== 64'hCAFE_F00D_1234_5678) begin errors++; $display("[TB] FAIL b2b_out2: got %h want cafef00d12345678", bus.out_data); end
    checks++; if (bus.word_count !== 16'd6) begin errors++; $display("[TB] FAIL b2b_count: got %0d want 6", bus.word_count); end
    step();
  endtask

  task automatic test_noop();
    bus.dump_comp = 1'b1;
    step();
    idle();
    checks++; if (bus.scon_done !== 1'b0) begin errors++; $display("[TB] FAIL noop_dump_done: got %b want 0", bus.scon_done); end
    checks++; if (bus.word_count !== 16'd6) begin errors++; $display("[TB] FAIL noop_dump_count: got %0d want 6", bus.word_count); end
    beat({64{1'b1}}, 7'd0, 1'b0);
    step();
    idle();
    checks++; if (bus.scon_done !== 1'b0) begin errors++; $display("[TB] FAIL noop_vb0_done: got %b want 0", bus.scon_done); end
    checks++; if (bus.fill_level !== 6'd0) begin errors++; $display("[TB] FAIL noop_vb0_fill: got %0d want 0", bus.fill_level); end
  endtask

  task automatic test_error();
    beat({64{1'b1}}, 7'd65, 1'b0);
    step();
    checks++; if (bus.bits_error !== 1'b1) begin errors++; $display("[TB] FAIL err_set: got %b want 1", bus.bits_error); end
    checks++; if (bus.fill_level !== 6'd0) begin errors++; $display("[TB] FAIL err_drop: got %0d want 0", bus.fill_level); end
    beat(64'h5555_5555_5555_5555, 7'd64, 1'b0);
    step();
    idle();
    checks++; if (bus.scon_done !== 1'b0) begin errors++; $display("[TB] FAIL err_ignore_done: got %b want 0", bus.scon_done); end
    checks++; if (bus.word_count !== 16'd6) begin errors++; $display("[TB] FAIL err_ignore_count: got %0d want 6", bus.word_count); end
    checks++; if (bus.bits_error !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b want 1", bus.bits_error); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.bits_error !== 1'b0) begin errors++; $display("[TB] FAIL err_rst_err: got %b want 0", bus.bits_error); end
    checks++; if (bus.word_count !== 16'd0) begin errors++; $display("[TB] FAIL err_rst_count: got %0d want 0", bus.word_count); end
    checks++; if (bus.out_data !== 64'd0) begin errors++; $display("[TB] FAIL err_rst_out: got %h want 0", bus.out_data); end
    checks++; if (bus.last_bits !== 7'd0) begin errors++; $display("[TB] FAIL err_rst_last: got %0d want 0", bus.last_bits); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    idle();
    test_reset();
    test_pack();
    test_dump();
    test_dump_overflow();
    test_stall();
    test_back_to_back();
    test_noop();
    test_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no completion want finish before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule
